// File: rtl/dmem_responder.sv
// In-order data-memory responder: request FIFO, 1024-word array, fixed-latency replies.
// Optional: DMEM_RESPONDER_WRITE_ACK_EN makes writes return a completion pulse too.
module dmem_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 2);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_e;

    logic [9:0]  fifo_idx  [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic        fifo_rw   [DEPTH];
    logic [3:0]  fifo_id   [DEPTH];
    logic [31:0] mem       [1024];

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [3:0]     fl_id_q;
    logic [31:0]    fl_data_q;
    logic           fl_rw_q;

    logic           push, pop, resp_edge, resp_fire;
    logic [9:0]     head_idx;
    logic [31:0]    head_data, head_word;
    logic           head_rw;
    logic [3:0]     head_id;
    logic           unused_addr;

    assign unused_addr = ^{addr_in[31:12], addr_in[1:0]};

    assign stall_out = (count_q == FULL);
    assign push      = valid_in && !stall_out;
    assign resp_edge = (state_q == BUSY) && (cnt_q == 4'd0);
    assign pop       = (count_q != '0) && ((state_q == IDLE) || resp_edge);

    assign head_idx  = fifo_idx[rd_ptr_q];
    assign head_data = fifo_data[rd_ptr_q];
    assign head_rw   = fifo_rw[rd_ptr_q];
    assign head_id   = fifo_id[rd_ptr_q];
    // Reads see every write popped on an earlier edge; this edge's write lands below.
    assign head_word = head_rw ? head_data : mem[head_idx];

`ifdef DMEM_RESPONDER_WRITE_ACK_EN
    logic unused_rw;
    assign unused_rw = fl_rw_q;
    assign resp_fire = resp_edge;
`else
    assign resp_fire = resp_edge && !fl_rw_q;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr_q]  <= addr_in[11:2];
            fifo_data[wr_ptr_q] <= data_in;
            fifo_rw[wr_ptr_q]   <= rw_in;
            fifo_id[wr_ptr_q]   <= id_in;
        end
        if (pop && head_rw)
            mem[head_idx] <= head_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fl_id_q   <= 4'd0;
            fl_data_q <= 32'd0;
            fl_rw_q   <= 1'b0;
            ready_out <= 1'b0;
            id_out    <= 4'd0;
            data_out  <= 32'd0;
        end else begin
            ready_out <= 1'b0;
            count_q   <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                fl_id_q   <= head_id;
                fl_data_q <= head_word;
                fl_rw_q   <= head_rw;
            end
            if (resp_fire) begin
                ready_out <= 1'b1;
                id_out    <= fl_id_q;
                data_out  <= fl_data_q;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0)
                        cnt_q <= cnt_q - 4'd1;
                    else if (pop)
                        cnt_q <= CNT_LOAD;
                    else
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=4, LATENCY=8).
// Expectations follow DMEM_RESPONDER_WRITE_ACK_EN when defined.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, data_in, data_out;
    logic        rw_in, valid_in, ready_out, stall_out;
    logic [3:0]  id_in, id_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pid[$];
    logic [31:0] pdata[$];
    int pcyc[$];
    logic st_hist [0:2047];
    int a0, a1, acc;
    int accs [8];
    localparam int EXP_ACC [8] = '{0, 1, 2, 3, 4, 9, 16, 23};

    dmem_responder #(.DEPTH(4), .LATENCY(8)) u_dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .rw_in(rw_in), .id_in(id_in), .valid_in(valid_in),
        .data_out(data_out), .id_out(id_out),
        .ready_out(ready_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 2048) st_hist[cyc] = stall_out;
        if (ready_out) begin
            pid.push_back(32'({28'd0, id_out}));
            pdata.push_back(data_out);
            pcyc.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear();
        pid.delete();
        pdata.delete();
        pcyc.delete();
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] id, output int acc_o);
        logic ok;
        int n;
        rw_in = w; addr_in = a; data_in = d; id_in = id; valid_in = 1'b1;
        ok = 1'b0; n = 0; acc_o = -1;
        while (!ok && n < 100) begin
            ok = !stall_out;
            tick();
            n++;
        end
        if (ok) acc_o = cyc;
        chk("accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic chk_pulse(input string tag, input int k, input int eid,
                             input logic [31:0] edata, input int ecyc);
        chk({tag, "_present"}, 32'(pid.size() > k), 32'd1);
        if (pid.size() > k) begin
            chk({tag, "_id"}, pid[k], eid);
            chk({tag, "_data"}, pdata[k], edata);
            chk({tag, "_cycle"}, pcyc[k], ecyc);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; rw_in = 1'b0;
        addr_in = 32'd0; data_in = 32'd0; id_in = 4'd0;
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_id", 32'(id_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        rst = 1'b1;
        idle(2);

        // back-to-back write then read of the same word
        clear();
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'd3, a0);
        send(1'b0, 32'h10, 32'h0, 4'd4, a1);
        idle(25);
        chk("b2b_accept", a1, a0 + 1);
`ifdef DMEM_RESPONDER_WRITE_ACK_EN
        chk("b2b_npulse", pid.size(), 2);
        chk_pulse("b2b_wr", 0, 3, 32'hDEADBEEF, a0 + 8);
        chk_pulse("b2b_rd", 1, 4, 32'hDEADBEEF, a0 + 15);
`else
        chk("b2b_npulse", pid.size(), 1);
        chk_pulse("b2b_rd", 0, 4, 32'hDEADBEEF, a0 + 15);
`endif

        // single read from idle
        send(1'b1, 32'h20, 32'h12345678, 4'd6, acc);
        idle(20);
        clear();
        send(1'b0, 32'h20, 32'h0, 4'd7, acc);
        idle(20);
        chk("lat_npulse", pid.size(), 1);
        chk_pulse("lat", 0, 7, 32'h12345678, acc + 8);

        // word index wraps: 0x1000 aliases 0x0
        send(1'b1, 32'h1000, 32'hA5A5A5A5, 4'd1, acc);
        idle(20);
        clear();
        send(1'b0, 32'h0, 32'h0, 4'd9, acc);
        idle(20);
        chk("alias_npulse", pid.size(), 1);
        chk_pulse("alias", 0, 9, 32'hA5A5A5A5, acc + 8);

        // write acknowledge behaviour
        clear();
        send(1'b1, 32'h44, 32'h0BADF00D, 4'd2, a0);
        idle(20);
`ifdef DMEM_RESPONDER_WRITE_ACK_EN
        chk("wack_npulse", pid.size(), 1);
        chk_pulse("wack", 0, 2, 32'h0BADF00D, a0 + 8);
`else
        chk("wack_npulse", pid.size(), 0);
`endif
        clear();
        send(1'b0, 32'h44, 32'h0, 4'd5, acc);
        idle(20);
        chk("rdw_npulse", pid.size(), 1);
        chk_pulse("rdw", 0, 5, 32'h0BADF00D, acc + 8);

        // fill and stall with valid held every cycle
        clear();
        for (int k = 0; k < 8; k++)
            send(1'b0, 32'h10, 32'h0, 4'(k), accs[k]);
        idle(70);
        for (int k = 0; k < 8; k++)
            chk($sformatf("fill_acc%0d", k), accs[k] - accs[0], EXP_ACC[k]);
        chk("stall_pre", 32'(st_hist[accs[0] + 3]), 32'd0);
        chk("stall_rise", 32'(st_hist[accs[0] + 4]), 32'd1);
        chk("stall_fall", 32'(st_hist[accs[0] + 8]), 32'd0);
        chk("stall_again", 32'(st_hist[accs[0] + 9]), 32'd1);
        chk("fill_npulse", pid.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_pulse($sformatf("fill%0d", k), k, k, 32'hDEADBEEF, accs[0] + 8 + 7 * k);

        // asynchronous reset while busy with a full FIFO
        clear();
        for (int k = 0; k < 5; k++)
            send(1'b0, 32'h20, 32'h0, 4'(8 + k), acc);
        chk("mid_stall_full", 32'(stall_out), 32'd1);
        valid_in = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready_out), 32'd0);
        chk("mid_rst_id", 32'(id_out), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        clear();
        idle(30);
        chk("post_rst_npulse", pid.size(), 0);
        send(1'b0, 32'h20, 32'h0, 4'd13, acc);
        idle(20);
        chk("post_rst_rd_npulse", pid.size(), 1);
        chk_pulse("post_rst_rd", 0, 13, 32'h12345678, acc + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
